// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/DIV unit with architectural HI/LO registers.
// Stalls EX while a 33-cycle multiply or divide is in flight.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [2:0]        Op,
  input  logic              Flush,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  output logic              EX_Stall,
  output logic              Busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb_r;
  logic                is_div;
  logic                neg_lo;
  logic                neg_hi;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;

  logic [2:0]          effop;
  logic                start;
  logic                sgn;
  logic                sa;
  logic                sb;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     msum;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  assign effop    = Flush ? OP_NONE : Op;
  assign Busy     = (state != S_IDLE);
  assign EX_Stall = Busy && (effop != OP_NONE);
  assign HI       = hi_r;
  assign LO       = lo_r;

  assign start = (state == S_IDLE) &&
                 (effop >= OP_MULT) &&
                 (effop <= OP_DIVU);
  assign sgn   = (effop == OP_MULT) ||
                 (effop == OP_DIV);
  assign sa    = sgn && OpA[DATA_W-1];
  assign sb    = sgn && OpB[DATA_W-1];
  assign abs_a = sa ? -OpA : OpA;
  assign abs_b = sb ? -OpB : OpB;

  // acc holds {partial product, multiplier} or {remainder, dividend}
  assign msum  = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                 {1'b0, (acc[0] ? opb_r : '0)};
  assign trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} -
                 {1'b0, opb_r};

  always_comb begin
    acc_nxt = {msum, acc[DATA_W-1:1]};
    if (is_div) begin
      if (trial[DATA_W])
        acc_nxt = {acc[2*DATA_W-2:0], 1'b0};
      else
        acc_nxt = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end
  end

  assign prod = neg_lo ? -acc : acc;
  assign quo  = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem  = neg_hi ? -acc[2*DATA_W-1:DATA_W]
                       : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb_r  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ITER;
            cnt    <= CW'(DATA_W);
            acc    <= {{DATA_W{1'b0}}, abs_a};
            opb_r  <= abs_b;
            is_div <= (effop == OP_DIV) || (effop == OP_DIVU);
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
          end else if (effop == OP_MTHI) begin
            hi_r <= OpA;
          end else if (effop == OP_MTLO) begin
            lo_r <= OpA;
          end
        end
        S_ITER: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= S_FIXUP;
        end
        S_FIXUP: begin
          state <= S_IDLE;
          if (is_div) begin
            hi_r <= rem;
            lo_r <= quo;
          end else begin
            hi_r <= prod[2*DATA_W-1:DATA_W];
            lo_r <= prod[DATA_W-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized bench for hilo_muldiv_unit against an arithmetic model.
// Tracks expected HI/LO and checks latency, stalls and reset abort.
module tb_hilo_muldiv_unit;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  Op;
  logic        Flush;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        EX_Stall;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk;
  int n_pass;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .Op(Op),
    .Flush(Flush),
    .OpA(OpA),
    .OpB(OpB),
    .EX_Stall(EX_Stall),
    .Busy(Busy),
    .HI(HI),
    .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo);
    longint sa;
    longint sb;
    longint r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    hi = '0;
    lo = '0;
    case (op)
      3'd1: begin
        r = sa * sb;
        p = r;
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd3: begin
        if (b == 0) begin
          hi = a;
          lo = (sa >= 0) ? 32'hFFFFFFFF : 32'd1;
        end else begin
          r = sa / sb;
          p = r;
          lo = p[31:0];
          r = sa % sb;
          p = r;
          hi = p[31:0];
        end
      end
      3'd4: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFFFFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int cyc;
    bit hold_ok;
    bit stall_ok;
    model(op, a, b, eh, el);
    @(negedge CLK);
    Op = op; OpA = a; OpB = b; Flush = 1'b0;
    #1;
    check("accept_stall", EX_Stall, 0);
    @(negedge CLK);
    Op = 3'd0;
    #1;
    cyc = 0; hold_ok = 1; stall_ok = 1;
    while (Busy && cyc < 100) begin
      cyc++;
      if (HI !== hi_m || LO !== lo_m) hold_ok = 0;
      if (EX_Stall !== 1'b0) stall_ok = 0;
      @(negedge CLK);
      #1;
    end
    check("busy_cycles", cyc, 33);
    check("hilo_hold", hold_ok, 1);
    check("idle_op_nostall", stall_ok, 1);
    check("res_hi", HI, eh);
    check("res_lo", LO, el);
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic mt(input bit to_lo, input logic [31:0] a);
    @(negedge CLK);
    Op = to_lo ? 3'd6 : 3'd5; OpA = a; Flush = 1'b0;
    #1;
    check("mt_stall", EX_Stall, 0);
    @(negedge CLK);
    Op = 3'd0;
    if (to_lo) lo_m = a; else hi_m = a;
    #1;
    check("mt_busy", Busy, 0);
    check("mt_hi", HI, hi_m);
    check("mt_lo", LO, lo_m);
  endtask

  task automatic mf_idle();
    @(negedge CLK);
    Op = 3'd7; Flush = 1'b0;
    #1;
    check("mf_stall", EX_Stall, 0);
    check("mf_hi", HI, hi_m);
    check("mf_lo", LO, lo_m);
    @(negedge CLK);
    Op = 3'd0;
  endtask

  task automatic stall_read(input bit fl);
    int stalls;
    int cyc;
    @(negedge CLK);
    Op = 3'd4; OpA = 32'd100; OpB = 32'd7; Flush = 1'b0;
    @(negedge CLK);
    Op = 3'd0;
    @(negedge CLK);
    Op = 3'd7; Flush = fl;
    #1;
    stalls = 0; cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      if (EX_Stall) stalls++;
      @(negedge CLK);
      #1;
    end
    check(fl ? "flush_stalls" : "read_stalls", stalls, fl ? 0 : 32);
    check("read_release", EX_Stall, 0);
    check("read_hi", HI, 32'd2);
    check("read_lo", LO, 32'd14);
    hi_m = 32'd2;
    lo_m = 32'd14;
    Op = 3'd0; Flush = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_chk = 0; n_pass = 0;
    hi_m = '0; lo_m = '0;
    RST_N = 1'b0; Op = 3'd1; Flush = 1'b0;
    OpA = 32'd3; OpB = 32'd4;
    #12;
    check("rst_busy", Busy, 0);
    check("rst_stall", EX_Stall, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    Op = 3'd0;
    @(negedge CLK);
    RST_N = 1'b1;

    mt(1'b0, 32'h1234);
    mt(1'b1, 32'hCAFE0001);
    mf_idle();

    run_op(3'd1, 32'hFFFFFFFD, 32'd7);
    check("mult_hi_k", HI, 32'hFFFFFFFF);
    check("mult_lo_k", LO, 32'hFFFFFFEB);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_hi_k", HI, 32'hFFFFFFFE);
    check("multu_lo_k", LO, 32'h00000001);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo_k", LO, 32'hFFFFFFFD);
    check("div_hi_k", HI, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo_k", LO, 32'h80000000);
    check("ovf_hi_k", HI, 32'h0);
    run_op(3'd4, 32'd100, 32'd0);
    check("divu0_hi_k", HI, 32'h64);
    check("divu0_lo_k", LO, 32'hFFFFFFFF);
    run_op(3'd3, 32'hFFFFFF00, 32'd0);
    run_op(3'd3, 32'd55, 32'd0);
    mf_idle();

    stall_read(1'b0);
    stall_read(1'b1);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      if (rop == 3'd5) mt(1'b0, ra);
      else if (rop == 3'd6) mt(1'b1, ra);
      else run_op(rop, ra, rb);
    end
    mf_idle();

    @(negedge CLK);
    Op = 3'd1; OpA = 32'h01234567; OpB = 32'h89;
    @(negedge CLK);
    Op = 3'd0;
    repeat (10) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    hi_m = '0; lo_m = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(3'd2, 32'd5, 32'd6);
    check("post_rst_lo", LO, 32'd30);
    check("post_rst_hi", HI, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
